// File: rtl/mult_operand_sequencer.sv
// Operand sequencer for the array multiplier. A debounced load key captures operand A and
// then operand B, waits for the product to settle, and registers the product with a valid flag.
module mult_operand_sequencer #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [N-1:0]     data_in,
    input  logic             load_n,
    input  logic [2*N-1:0]   product_in,
    output logic [N-1:0]     op_a,
    output logic [N-1:0]     op_b,
    output logic [2*N-1:0]   product_q,
    output logic             valid,
    output logic [2*N-1:0]   disp_val,
    output logic [1:0]       state_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    logic            key_s1_q, key_s2_q;
    logic            key_deb_q, key_deb_d;
    logic            key_deb_prev_q;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [N-1:0]    data_s1_q, data_s2_q;
    logic            press;

    state_t          state_q, state_d;
    logic [N-1:0]    op_a_q, op_a_d;
    logic [N-1:0]    op_b_q, op_b_d;
    logic [2*N-1:0]  prod_q, prod_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   settle_cnt_q, settle_cnt_d;

    // Debouncer: the level only moves after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        key_deb_d = key_deb_q;
        deb_cnt_d = '0;
        if (key_s2_q != key_deb_q) begin
            if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                key_deb_d = key_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
    end

    // Only the falling edge of the debounced level counts as a press.
    assign press = key_deb_prev_q & ~key_deb_q;

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        prod_d       = prod_q;
        valid_d      = valid_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            WAIT_A: begin
                if (press) begin
                    op_a_d  = data_s2_q;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (press) begin
                    op_b_d       = data_s2_q;
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    prod_d  = product_in;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    settle_cnt_d = settle_cnt_q + CW'(1);
                end
            end
            DONE: begin
                // The rearming press doubles as the capture of the next operand A.
                if (press) begin
                    op_a_d  = data_s2_q;
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            key_s1_q       <= 1'b1;
            key_s2_q       <= 1'b1;
            key_deb_q      <= 1'b1;
            key_deb_prev_q <= 1'b1;
            deb_cnt_q      <= '0;
            data_s1_q      <= '0;
            data_s2_q      <= '0;
            state_q        <= WAIT_A;
            op_a_q         <= '0;
            op_b_q         <= '0;
            prod_q         <= '0;
            valid_q        <= 1'b0;
            settle_cnt_q   <= '0;
        end else begin
            key_s1_q       <= load_n;
            key_s2_q       <= key_s1_q;
            key_deb_q      <= key_deb_d;
            key_deb_prev_q <= key_deb_q;
            deb_cnt_q      <= deb_cnt_d;
            data_s1_q      <= data_in;
            data_s2_q      <= data_s1_q;
            state_q        <= state_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            prod_q         <= prod_d;
            valid_q        <= valid_d;
            settle_cnt_q   <= settle_cnt_d;
        end
    end

    always_comb begin
        disp_val = prod_q;
        case (state_q)
            WAIT_A:  disp_val = {{N{1'b0}}, data_s2_q};
            WAIT_B:  disp_val = {op_a_q, data_s2_q};
            SETTLE:  disp_val = {op_a_q, op_b_q};
            DONE:    disp_val = prod_q;
            default: disp_val = prod_q;
        endcase
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign product_q = prod_q;
    assign valid     = valid_q;
    assign state_o   = state_q;

endmodule
